// File: rtl/tlc_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tlc_phase_scheduler
// Purpose  : Round-robin phase scheduler sequencing GREEN -> YELLOW -> ALLRED.
//            Optional emergency preemption when TLC_PREEMPT_EN is defined.
// Revision : 1.0
// ============================================================================
module tlc_phase_scheduler #(
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] req_in,
`ifdef TLC_PREEMPT_EN
  input  logic       preempt_req,
  input  logic [1:0] preempt_phase,
`endif
  output logic [1:0] phase_id,
  output logic [1:0] stage,
  output logic [7:0] timer,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } stage_t;

  stage_t     r_stage, w_stage_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic [3:0] r_pending, w_pending_nxt;

  logic [8:0] w_timer_p1;
  logic [3:0] w_green_mask;
  logic [3:0] w_others;
  logic [1:0] w_p1, w_p2, w_p3;
  logic [1:0] w_rr_phase;
  logic [1:0] w_next_phase;
  logic       w_pre_force;
  logic       w_pre_hold;
  logic       w_green_done;
  logic       w_change;
  logic [3:0] w_set;
  logic [3:0] w_clear;

  assign w_timer_p1   = {1'b0, r_timer} + 9'd1;
  assign w_green_mask = (r_stage == ST_GREEN) ? (4'b0001 << r_phase) : 4'b0000;
  assign w_others     = r_pending & ~(4'b0001 << r_phase);

  // Nearest pending phase after the current one; phase 0 when nothing waits.
  assign w_p1 = r_phase + 2'd1;
  assign w_p2 = r_phase + 2'd2;
  assign w_p3 = r_phase + 2'd3;
  assign w_rr_phase = r_pending[w_p1] ? w_p1 :
                      r_pending[w_p2] ? w_p2 :
                      r_pending[w_p3] ? w_p3 : 2'd0;

`ifdef TLC_PREEMPT_EN
  assign w_pre_force  = preempt_req && (r_phase != preempt_phase);
  assign w_pre_hold   = preempt_req && (r_phase == preempt_phase);
  assign w_next_phase = preempt_req ? preempt_phase : w_rr_phase;
`else
  assign w_pre_force  = 1'b0;
  assign w_pre_hold   = 1'b0;
  assign w_next_phase = w_rr_phase;
`endif

  // Side phases always hand back to the rest phase once minimum green is served.
  assign w_green_done = tick && !w_pre_hold &&
                        (w_pre_force ||
                         ((w_timer_p1 >= 9'(MIN_GREEN)) && ((|w_others) || (r_phase != 2'd0))));

  always_comb begin
    w_stage_nxt = r_stage;
    w_phase_nxt = r_phase;
    w_change    = 1'b0;
    w_clear     = 4'b0000;
    w_set       = req_in & ~w_green_mask;
    case (r_stage)
      ST_GREEN: begin
        if (w_green_done) begin
          w_change    = 1'b1;
          w_stage_nxt = r_phase[1] ? ST_ALLRED : ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (tick && (w_timer_p1 == 9'(YELLOW_T))) begin
          w_change    = 1'b1;
          w_stage_nxt = ST_ALLRED;
        end
      end
      ST_ALLRED: begin
        if (tick && (w_timer_p1 == 9'(ALLRED_T))) begin
          w_change    = 1'b1;
          w_stage_nxt = ST_GREEN;
          w_phase_nxt = w_next_phase;
          w_clear     = 4'b0001 << w_next_phase;
        end
      end
      default: begin
        w_change    = 1'b1;
        w_stage_nxt = ST_GREEN;
        w_phase_nxt = 2'd0;
      end
    endcase

    w_pending_nxt = (r_pending | w_set) & ~w_clear;

    if (w_change) begin
      w_timer_nxt = 8'd0;
    end else if (tick && (r_timer != 8'hFF)) begin
      w_timer_nxt = r_timer + 8'd1;
    end else begin
      w_timer_nxt = r_timer;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage   <= ST_GREEN;
      r_phase   <= 2'd0;
      r_timer   <= 8'd0;
      r_pending <= 4'b0000;
    end else begin
      r_stage   <= w_stage_nxt;
      r_phase   <= w_phase_nxt;
      r_timer   <= w_timer_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign phase_id = r_phase;
  assign stage    = r_stage;
  assign timer    = r_timer;
  assign pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_phase_scheduler
// Purpose  : Self-checking bench for tlc_phase_scheduler against a rule model.
// Revision : 1.0
// ============================================================================
module tb_tlc_phase_scheduler;

  localparam int MIN_GREEN = 10;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] req_in = 4'b0000;
  logic [1:0] phase_id;
  logic [1:0] stage;
  logic [7:0] timer;
  logic [3:0] pending;
  logic [15:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: which phase, which stage, ticks in stage, latched requests.
  int m_phase, m_stage, m_timer;
  logic [3:0] m_pend;

  tlc_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .req_in  (req_in),
`ifdef TLC_PREEMPT_EN
    .preempt_req  (1'b0),
    .preempt_phase(2'b00),
`endif
    .phase_id(phase_id),
    .stage   (stage),
    .timer   (timer),
    .pending (pending)
  );

  assign dut_vec = {phase_id, stage, timer, pending};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_vec();
    logic [1:0] p, s;
    logic [7:0] t;
    p = 2'(m_phase);
    s = 2'(m_stage);
    t = 8'(m_timer);
    return {p, s, t, m_pend};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_stage = 0;
    m_timer = 0;
    m_pend  = 4'b0000;
  endtask

  task automatic model_step(input bit t, input logic [3:0] r);
    logic [3:0] np;
    int nph, nst, k;
    bit chg, others;
    np  = m_pend;
    nph = m_phase;
    nst = m_stage;
    chg = 0;
    for (int i = 0; i < 4; i++)
      if (r[i] && !(m_stage == 0 && m_phase == i)) np[i] = 1'b1;
    if (t) begin
      if (m_stage == 0) begin
        others = 0;
        for (int i = 0; i < 4; i++) if (i != m_phase && m_pend[i]) others = 1;
        if (m_timer + 1 >= MIN_GREEN && (others || m_phase != 0)) begin
          chg = 1;
          nst = (m_phase < 2) ? 1 : 2;
        end
      end else if (m_stage == 1) begin
        if (m_timer + 1 == YELLOW_T) begin chg = 1; nst = 2; end
      end else begin
        if (m_timer + 1 == ALLRED_T) begin
          chg = 1;
          nst = 0;
          nph = 0;
          for (int d = 3; d >= 1; d--) begin
            k = (m_phase + d) % 4;
            if (m_pend[k]) nph = k;
          end
          np[nph] = 1'b0;
        end
      end
    end
    if (chg) m_timer = 0;
    else if (t && m_timer < 255) m_timer = m_timer + 1;
    m_phase = nph;
    m_stage = nst;
    m_pend  = np;
  endtask

  // Called at posedge+1: drive, advance one clock, update model, settle.
  task automatic step(input bit t, input logic [3:0] r);
    tick   = t;
    req_in = r;
    @(posedge clk);
    model_step(t, r);
    #1;
  endtask

  task automatic apply_reset();
    tick   = 1'b0;
    req_in = 4'b0000;
    reset  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (dut_vec !== 16'h0000) $display("FAIL reset_values: got %h expected 0000", dut_vec);
    else n_pass++;
    apply_reset();
    for (int tk = 0; tk < 300; tk++) begin
      for (int c = 0; c < 10; c++) begin
        step(c == 9, 4'b0000);
        n_checks++;
        if (dut_vec !== model_vec())
          $display("FAIL idle_rest: tick %0d got %h expected %h", tk, dut_vec, model_vec());
        else n_pass++;
      end
    end
    n_checks++;
    if ({phase_id, stage, timer, pending} !== {2'd0, 2'd0, 8'd255, 4'd0})
      $display("FAIL idle_saturate: got ph=%0d st=%0d tm=%0d pd=%b expected 0 0 255 0000",
               phase_id, stage, timer, pending);
    else n_pass++;
  endtask

  task automatic test_single_request();
    apply_reset();
    for (int tk = 1; tk <= 14; tk++) begin
      for (int c = 0; c < 10; c++) begin
        step(c == 9, (tk == 2 && c == 0) ? 4'b0010 : 4'b0000);
        n_checks++;
        if (dut_vec !== model_vec())
          $display("FAIL single_req: tick %0d got %h expected %h", tk, dut_vec, model_vec());
        else n_pass++;
      end
      if (tk == 10) begin
        n_checks++;
        if ({phase_id, stage} !== {2'd0, 2'd1})
          $display("FAIL single_yellow: got ph=%0d st=%0d expected 0 1", phase_id, stage);
        else n_pass++;
      end
      if (tk == 13) begin
        n_checks++;
        if ({phase_id, stage} !== {2'd0, 2'd2})
          $display("FAIL single_allred: got ph=%0d st=%0d expected 0 2", phase_id, stage);
        else n_pass++;
      end
    end
    n_checks++;
    if ({phase_id, stage, timer, pending} !== {2'd1, 2'd0, 8'd0, 4'b0000})
      $display("FAIL single_green1: got ph=%0d st=%0d tm=%0d pd=%b expected 1 0 0 0000",
               phase_id, stage, timer, pending);
    else n_pass++;
  endtask

  task automatic test_ped_order();
    int order[$];
    logic [1:0] prev_stage;
    bit saw_ped_yellow;
    apply_reset();
    prev_stage = 2'd0;
    saw_ped_yellow = 0;
    for (int tk = 0; tk < 60; tk++) begin
      for (int c = 0; c < 10; c++) begin
        step(c == 9, (tk == 0 && c == 0) ? 4'b1100 : 4'b0000);
        n_checks++;
        if (dut_vec !== model_vec())
          $display("FAIL ped_order: tick %0d got %h expected %h", tk, dut_vec, model_vec());
        else n_pass++;
        if (stage == 2'd0 && prev_stage != 2'd0) order.push_back(int'(phase_id));
        if (stage == 2'd1 && phase_id[1]) saw_ped_yellow = 1;
        prev_stage = stage;
      end
    end
    n_checks++;
    if (order.size() != 3 || order[0] != 2 || order[1] != 3 || order[2] != 0)
      $display("FAIL ped_sequence: got %p expected '{2, 3, 0}", order);
    else n_pass++;
    n_checks++;
    if (saw_ped_yellow) $display("FAIL ped_no_yellow: got yellow on ped phase expected none");
    else n_pass++;
  endtask

  task automatic test_cross_hold();
    int order[$];
    logic [1:0] prev_stage;
    logic [3:0] r;
    apply_reset();
    prev_stage = 2'd0;
    for (int tk = 1; tk <= 45; tk++) begin
      for (int c = 0; c < 10; c++) begin
        r = 4'b0000;
        if (tk == 2 && c == 0) r = 4'b0010;
        if (tk == 15) r = 4'b0010;
        if (tk == 16 && c == 0) r = 4'b1001;
        step(c == 9, r);
        n_checks++;
        if (dut_vec !== model_vec())
          $display("FAIL cross_hold: tick %0d got %h expected %h", tk, dut_vec, model_vec());
        else n_pass++;
        if (stage == 2'd0 && prev_stage != 2'd0) order.push_back(int'(phase_id));
        prev_stage = stage;
      end
      if (tk == 15) begin
        n_checks++;
        if ({phase_id, stage, pending} !== {2'd1, 2'd0, 4'b0000})
          $display("FAIL cross_drop: got ph=%0d st=%0d pd=%b expected 1 0 0000",
                   phase_id, stage, pending);
        else n_pass++;
      end
    end
    n_checks++;
    if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 0)
      $display("FAIL cross_sequence: got %p expected '{1, 3, 0}", order);
    else n_pass++;
  endtask

  task automatic test_reset_midstage();
    int guard;
    apply_reset();
    step(1'b0, 4'b0010);
    guard = 0;
    while (!(phase_id == 2'd1 && stage == 2'd1) && guard < 400) begin
      step((guard % 10) == 9, 4'b0000);
      n_checks++;
      if (dut_vec !== model_vec())
        $display("FAIL midreset_run: cycle %0d got %h expected %h", guard, dut_vec, model_vec());
      else n_pass++;
      guard++;
    end
    n_checks++;
    if (guard >= 400) $display("FAIL midreset_reach: got no phase 1 yellow within 400 cycles expected yellow");
    else n_pass++;
    step(1'b0, 4'b0100);
    n_checks++;
    if ({phase_id, stage, pending} !== {2'd1, 2'd1, 4'b0100})
      $display("FAIL midreset_pre: got ph=%0d st=%0d pd=%b expected 1 1 0100", phase_id, stage, pending);
    else n_pass++;
    tick = 1'b0;
    req_in = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 16'h0000) $display("FAIL midreset_async: got %h expected 0000", dut_vec);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    int gap;
    logic [3:0] r;
    apply_reset();
    for (int tk = 0; tk < 400; tk++) begin
      gap = $urandom_range(12, 1);
      for (int c = 0; c < gap; c++) begin
        r = ($urandom_range(24, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'b0000;
        step(c == gap - 1, r);
        n_checks++;
        if (dut_vec !== model_vec())
          $display("FAIL random: tick %0d got %h expected %h", tk, dut_vec, model_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_request();
    test_ped_order();
    test_cross_hold();
    test_reset_midstage();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
